// File: rtl/parallel_to_serial_stream.sv
// Word-to-serial shifter with framing, beat strobe, word_done and flush.
// Define PARALLEL_TO_SERIAL_STREAM_PREFETCH_EN for a one-word holding register.
module parallel_to_serial_stream #(
  parameter int DATA_W    = 8,
  parameter int LANES     = 1,
  parameter int CLK_DIV   = 1,
  parameter int MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [LANES-1:0]  ser_data,
  output logic              ser_frame,
  output logic              ser_strobe,
  output logic              word_done
);

  localparam int BEATS  = DATA_W / LANES;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [DIV_W-1:0]  LAST_DIV  = DIV_W'(CLK_DIV - 1);

  if (DATA_W % LANES != 0) begin : g_chk_w
    $error("DATA_W must be a multiple of LANES");
  end
  if (CLK_DIV < 1) begin : g_chk_div
    $error("CLK_DIV must be at least 1");
  end

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   sh_q, sh_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic                hs;
  logic                beat_end;
  logic                word_end;
  logic [DATA_W-1:0]   sh_adv;

`ifdef PARALLEL_TO_SERIAL_STREAM_PREFETCH_EN
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic                hold_vld_q, hold_vld_d;

  // Ready tracks only the holding slot, so a word can queue mid-shift.
  assign in_ready = rstn & ~flush & ~hold_vld_q;
`else
  assign in_ready = rstn & ~flush & (state_q == IDLE);
`endif

  assign hs       = in_valid & in_ready;
  assign beat_end = (state_q == SHIFT) && (div_q == LAST_DIV);
  assign word_end = beat_end && (beat_q == LAST_BEAT);
  assign sh_adv   = (MSB_FIRST != 0) ? (sh_q << LANES) : (sh_q >> LANES);

  assign ser_frame  = (state_q == SHIFT);
  assign ser_strobe = ser_frame && (div_q == '0);
  assign word_done  = word_end;
  assign ser_data   = !ser_frame ? '0 :
                      (MSB_FIRST != 0) ? sh_q[DATA_W-1 -: LANES] :
                                         sh_q[LANES-1:0];

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    beat_d  = beat_q;
    div_d   = div_q;
`ifdef PARALLEL_TO_SERIAL_STREAM_PREFETCH_EN
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
`endif
    if (flush) begin
      state_d = IDLE;
      sh_d    = '0;
      beat_d  = '0;
      div_d   = '0;
`ifdef PARALLEL_TO_SERIAL_STREAM_PREFETCH_EN
      hold_d     = '0;
      hold_vld_d = 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (hs) begin
            sh_d    = in_data;
            beat_d  = '0;
            div_d   = '0;
            state_d = SHIFT;
          end
        end
        SHIFT: begin
`ifdef PARALLEL_TO_SERIAL_STREAM_PREFETCH_EN
          if (hs && !word_end) begin
            hold_d     = in_data;
            hold_vld_d = 1'b1;
          end
`endif
          if (!beat_end) begin
            div_d = div_q + DIV_W'(1);
          end else begin
            div_d = '0;
            if (beat_q != LAST_BEAT) begin
              beat_d = beat_q + BEAT_W'(1);
              sh_d   = sh_adv;
            end else begin
              beat_d = '0;
`ifdef PARALLEL_TO_SERIAL_STREAM_PREFETCH_EN
              if (hold_vld_q) begin
                sh_d       = hold_q;
                hold_vld_d = 1'b0;
              end else if (hs) begin
                sh_d = in_data;
              end else begin
                state_d = IDLE;
                sh_d    = '0;
              end
`else
              state_d = IDLE;
              sh_d    = '0;
`endif
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      sh_q    <= '0;
      beat_q  <= '0;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      beat_q  <= beat_d;
      div_q   <= div_d;
    end
  end

`ifdef PARALLEL_TO_SERIAL_STREAM_PREFETCH_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
    end else begin
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
    end
  end
`endif

endmodule

// File: tb/tb_parallel_to_serial_stream.sv
// Scoreboard bench: three serializer configurations, expected beats
// pushed at handshake and popped by a negedge monitor.
module tb_parallel_to_serial_stream;

  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rn[N];
  logic       fl[N];
  logic       iv[N];
  logic [7:0] id[N];

  logic       rdy_a, fr_a, st_a, wd_a;
  logic [0:0] sd_a;
  logic       rdy_b, fr_b, st_b, wd_b;
  logic [1:0] sd_b;
  logic       rdy_c, fr_c, st_c, wd_c;
  logic [1:0] sd_c;

  // A: 1 lane, div 1, MSB first
  parallel_to_serial_stream #(
    .DATA_W(8), .LANES(1), .CLK_DIV(1), .MSB_FIRST(1)
  ) u_a (
    .clk(clk), .rstn(rn[0]), .flush(fl[0]),
    .in_valid(iv[0]), .in_ready(rdy_a), .in_data(id[0]),
    .ser_data(sd_a), .ser_frame(fr_a),
    .ser_strobe(st_a), .word_done(wd_a)
  );

  // B: 2 lanes, div 1, MSB first
  parallel_to_serial_stream #(
    .DATA_W(8), .LANES(2), .CLK_DIV(1), .MSB_FIRST(1)
  ) u_b (
    .clk(clk), .rstn(rn[1]), .flush(fl[1]),
    .in_valid(iv[1]), .in_ready(rdy_b), .in_data(id[1]),
    .ser_data(sd_b), .ser_frame(fr_b),
    .ser_strobe(st_b), .word_done(wd_b)
  );

  // C: 2 lanes, div 3, LSB first
  parallel_to_serial_stream #(
    .DATA_W(8), .LANES(2), .CLK_DIV(3), .MSB_FIRST(0)
  ) u_c (
    .clk(clk), .rstn(rn[2]), .flush(fl[2]),
    .in_valid(iv[2]), .in_ready(rdy_c), .in_data(id[2]),
    .ser_data(sd_c), .ser_frame(fr_c),
    .ser_strobe(st_c), .word_done(wd_c)
  );

  // {ready, frame, done, strobe, data[1:0]}
  logic [5:0] ob[N];
  always_comb begin
    ob[0] = {rdy_a, fr_a, wd_a, st_a, 1'b0, sd_a};
    ob[1] = {rdy_b, fr_b, wd_b, st_b, sd_b};
    ob[2] = {rdy_c, fr_c, wd_c, st_c, sd_c};
  end

  logic [3:0] expq[N][$];
  int total = 0;
  int bad   = 0;

  bit trk = 1'b0;
  int t_fr, t_wd, t_gap, t_pend;
  bit t_st, t_rlo, t_rhi;

  task automatic chk(int i, string nm, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d got=%0h want=%0h", nm, i, act, exp);
    end
  endtask

  task automatic push_exp(int i, logic [15:0] bts);
    int nb = (i == 0) ? 8 : 4;
    int dv = (i == 2) ? 3 : 1;
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < dv; c++) begin
        logic dn = (b == nb - 1) && (c == dv - 1);
        logic sb = (c == 0);
        expq[i].push_back({dn, sb, bts[15-2*b -: 2]});
      end
    end
  endtask

  task automatic send(int i, logic [7:0] w, logic [15:0] bts);
    int n = 0;
    @(negedge clk);
    iv[i] = 1'b1;
    id[i] = w;
    while (!ob[i][5] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      chk(i, "send_timeout", n, 0);
    end else begin
      push_exp(i, bts);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle(int i);
    int n = 0;
    while ((expq[i].size() != 0 || ob[i][4]) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk(i, "idle_timeout", n, 0);
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (ob[i][4]) begin
        if (expq[i].size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexp_frame dut%0d got=%0h", i, ob[i]);
        end else begin
          logic [3:0] e;
          e = expq[i].pop_front();
          chk(i, "beat", int'(ob[i][3:0]), int'(e));
        end
      end else begin
        chk(i, "unframed_zero", int'(ob[i][3:0]), 0);
      end
    end
`ifndef PARALLEL_TO_SERIAL_STREAM_PREFETCH_EN
    if (fr_a) chk(0, "rdy_in_shift", int'(rdy_a), 0);
`endif
    if (trk) begin
      if (fr_a) begin
        t_fr++;
        if (t_st) t_gap += t_pend;
        t_pend = 0;
        t_st   = 1'b1;
        if (rdy_a) t_rhi = 1'b1;
        else t_rlo = 1'b1;
      end else if (t_st) begin
        t_pend++;
      end
      if (wd_a) t_wd++;
    end
  end

  initial begin
    int n;
    for (int i = 0; i < N; i++) begin
      rn[i] = 1'b0;
      fl[i] = 1'b0;
      iv[i] = 1'b0;
      id[i] = 8'h00;
    end
    repeat (2) @(negedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      chk(i, "rst_outs", int'(ob[i][3:0]), 0);
      chk(i, "rst_rdy", int'(ob[i][5]), 0);
      rn[i] = 1'b1;
    end
    #1;
    for (int i = 0; i < N; i++) chk(i, "rdy_after_rst", int'(ob[i][5]), 1);

    // 0xA5 single lane: 1,0,1,0,0,1,0,1
    send(0, 8'hA5, 16'b01_00_01_00_00_01_00_01);
    iv[0] = 1'b0;
    wait_idle(0);

    // 0xB4 two lanes MSB first: 10,11,01,00
    send(1, 8'hB4, 16'b10_11_01_00_00_00_00_00);
    iv[1] = 1'b0;
    wait_idle(1);
    // 0x6C: 01,10,11,00
    send(1, 8'h6C, 16'b01_10_11_00_00_00_00_00);
    iv[1] = 1'b0;
    wait_idle(1);

    // 0xB4 two lanes LSB first, 3 cycles/beat: 00,01,11,10
    send(2, 8'hB4, 16'b00_01_11_10_00_00_00_00);
    iv[2] = 1'b0;
    wait_idle(2);
    // 0x80: 00,00,00,10
    send(2, 8'h80, 16'b00_00_00_10_00_00_00_00);
    iv[2] = 1'b0;
    wait_idle(2);

    // Flush during beat 3 of 0xFF with a competing valid word
    send(0, 8'hFF, 16'b01_01_01_01_01_01_01_01);
    iv[0] = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    fl[0] = 1'b1;
    iv[0] = 1'b1;
    id[0] = 8'h77;
    expq[0].delete();
    #1;
    chk(0, "flush_rdy", int'(rdy_a), 0);
    @(negedge clk);
    chk(0, "flush_frame", int'(fr_a), 0);
    #1;
    fl[0] = 1'b0;
    iv[0] = 1'b0;
    // 0x3C: 0,0,1,1,1,1,0,0
    send(0, 8'h3C, 16'b00_00_01_01_01_01_00_00);
    iv[0] = 1'b0;
    wait_idle(0);

    // Back-to-back words with valid held high
    t_fr = 0; t_wd = 0; t_gap = 0; t_pend = 0;
    t_st = 1'b0; t_rlo = 1'b0; t_rhi = 1'b0;
    trk = 1'b1;
    send(0, 8'h12, 16'b00_00_00_01_00_00_01_00);
    send(0, 8'h34, 16'b00_00_01_01_00_01_00_00);
    send(0, 8'h56, 16'b00_01_00_01_00_01_01_00);
    iv[0] = 1'b0;
    n = 0;
    while (t_wd < 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    wait_idle(0);
    trk = 1'b0;
    chk(0, "stream_done", t_wd, 3);
    chk(0, "stream_frame", t_fr, 24);
    chk(0, "stream_rdy_low", int'(t_rlo), 1);
`ifdef PARALLEL_TO_SERIAL_STREAM_PREFETCH_EN
    chk(0, "stream_gap", t_gap, 0);
    chk(0, "stream_rdy_high", int'(t_rhi), 1);
`else
    chk(0, "stream_gap", t_gap, 2);
    chk(0, "stream_rdy_high", int'(t_rhi), 0);
`endif

    // Reset in the middle of a word
    send(0, 8'hA5, 16'b01_00_01_00_00_01_00_01);
    iv[0] = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    rn[0] = 1'b0;
    expq[0].delete();
    #1;
    chk(0, "midrst_outs", int'(ob[0]), 0);
    @(negedge clk);
    #1;
    rn[0] = 1'b1;
    #1;
    chk(0, "midrst_rdy", int'(rdy_a), 1);
    chk(0, "midrst_frame", int'(fr_a), 0);
    send(0, 8'h56, 16'b00_01_00_01_00_01_01_00);
    iv[0] = 1'b0;
    wait_idle(0);

    for (int i = 0; i < N; i++) chk(i, "q_empty", expq[i].size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
